// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera register-configuration sequencer.
package cam_cfg_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [3:0] {
    ST_PWR,
    ST_GAP,
    ST_XFER,
    ST_CHECK,
    ST_FAIL,
    ST_DLY,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } cfg_state_e;

  // One table entry: SLV=[31:24], REG=[23:8], VAL=[7:0]
  typedef struct packed {
    logic [7:0]  slv;
    logic [15:0] reg_addr;
    logic [7:0]  val;
  } cfg_entry_t;

  localparam logic [7:0] DELAY_TAG = 8'hFF;
  localparam logic       ACK_OK    = 1'b0;

  function automatic logic is_delay(cfg_entry_t e);
    return e.slv == DELAY_TAG;
  endfunction

endpackage

// File: rtl/i2c_reg_config_if.sv
// Table, i2c_com handshake and status signals of the configuration sequencer.
interface i2c_reg_config_if
  import cam_cfg_pkg::*;
#(
  parameter int unsigned IDX_W = 8
);
  logic              reconfig;
  logic [IDX_W-1:0]  lut_index;
  logic [DATA_W-1:0] lut_data;
  logic [DATA_W-1:0] i2c_data;
  logic              start;
  logic              tr_end;
  logic              ack;
  logic              cfg_done;
  logic              cfg_error;

  modport master (
    input  reconfig, lut_data, tr_end, ack,
    output lut_index, i2c_data, start, cfg_done, cfg_error
  );

  modport slave (
    output reconfig, lut_data, tr_end, ack,
    input  lut_index, i2c_data, start, cfg_done, cfg_error
  );
endinterface

// File: rtl/i2c_reg_config.sv
// Walks the camera register table, hands each write to i2c_com, retries NACKs/timeouts
// and executes in-table delay entries; reports cfg_done or cfg_error.
module i2c_reg_config
  import cam_cfg_pkg::*;
#(
  parameter int unsigned LUT_SIZE     = 256,
  parameter int unsigned POWER_DLY    = 400,
  parameter int unsigned GAP_CYCLES   = 4,   // must be >= 2: latch first, branch on the latch
  parameter int unsigned XFER_TIMEOUT = 63,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned DELAY_UNIT   = 20
) (
  input  logic        clock_i2c,
  input  logic        camera_rst,
  i2c_reg_config_if.master bus
);

  localparam int unsigned IDX_W = (LUT_SIZE > 1) ? $clog2(LUT_SIZE) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(POWER_DLY - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] XFER_LAST = CNT_W'(XFER_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(LUT_SIZE - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

  cfg_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;        // cycles spent in the current state
  logic [RTY_W-1:0] retry_q;
  logic [IDX_W-1:0] idx_q;
  cfg_entry_t       data_q;
  logic             start_q;
  logic             ack_q;
  logic             done_q;
  logic             err_q;

  logic [CNT_W-1:0] dly_len_c;
  logic             dly_over_c;

  // Delay entries: value[7:0] units, a zero value leaves after a single cycle
  assign dly_len_c  = CNT_W'(data_q.val) * CNT_W'(DELAY_UNIT);
  assign dly_over_c = (cnt_q + CNT_W'(1)) >= dly_len_c;

  always_ff @(posedge clock_i2c or posedge camera_rst) begin
    if (camera_rst) begin
      state_q <= ST_PWR;
      cnt_q   <= '0;
      retry_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      ack_q   <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (bus.reconfig) begin
      // Restart from entry 0; any in-flight result is dropped
      state_q <= ST_GAP;
      cnt_q   <= '0;
      retry_q <= '0;
      idx_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      cnt_q   <= cnt_q + CNT_W'(1);
      unique case (state_q)
        ST_PWR: begin
          if (cnt_q == PWR_LAST) begin
            state_q <= ST_GAP;
            cnt_q   <= '0;
          end
        end
        ST_GAP: begin
          data_q <= bus.lut_data;
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (is_delay(data_q)) begin
              state_q <= ST_DLY;
            end else begin
              state_q <= ST_XFER;
              start_q <= 1'b1;
            end
          end
        end
        ST_XFER: begin
          start_q <= 1'b1;
          if (bus.tr_end) begin
            ack_q   <= bus.ack;
            state_q <= ST_CHECK;
            start_q <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == XFER_LAST) begin
            state_q <= ST_FAIL;
            start_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        ST_CHECK: begin
          state_q <= (ack_q == ACK_OK) ? ST_NEXT : ST_FAIL;
          cnt_q   <= '0;
        end
        ST_FAIL: begin
          cnt_q <= '0;
          if (retry_q < RTY_MAX) begin
            retry_q <= retry_q + RTY_W'(1);
            state_q <= ST_GAP;
          end else begin
            err_q   <= 1'b1;
            state_q <= ST_ERR;
          end
        end
        ST_DLY: begin
          if (dly_over_c) begin
            state_q <= ST_NEXT;
            cnt_q   <= '0;
          end
        end
        ST_NEXT: begin
          retry_q <= '0;
          cnt_q   <= '0;
          if (idx_q == IDX_LAST) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= ST_GAP;
          end
        end
        ST_DONE, ST_ERR: begin
          cnt_q <= '0;
        end
        default: begin
          state_q <= ST_ERR;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.lut_index = idx_q;
  assign bus.i2c_data  = data_q;
  assign bus.start     = start_q;
  assign bus.cfg_done  = done_q;
  assign bus.cfg_error = err_q;

endmodule
